// File: rtl/shift_console_pkg.sv
// Shared constants for the shift console: mode and direction encodings and
// the legal parameter bounds checked when the top level is elaborated.
package shift_console_pkg;

    localparam logic [1:0] MODE_LOGICAL = 2'b00;
    localparam logic [1:0] MODE_ARITH   = 2'b01;
    localparam logic [1:0] MODE_ROTATE  = 2'b10;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int WIDTH_A   = 8;
    localparam int WIDTH_B   = 16;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 16;

    function automatic bit params_legal(input int width, input int depth);
        return ((width == WIDTH_A) || (width == WIDTH_B)) &&
               (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
    endfunction

endpackage

// File: rtl/shift_console_core.sv
// Combinational shift/rotate datapath.
// Ports: num (operand), amt (shift amount), mode (logical/arith/rotate;
// 2'b11 behaves as logical), dir (left/right), shifted (result).
module shift_core
    import shift_console_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] num,
    input  logic [AW-1:0]    amt,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [WIDTH-1:0] shifted
);

    logic signed [WIDTH-1:0] s_num;
    logic [WIDTH-1:0]        rotl;
    logic [WIDTH-1:0]        rotr;
    logic [WIDTH-1:0]        sra;

    assign s_num = $signed(num);
    // A shift by WIDTH yields zero, so amt = 0 rotates to num unchanged.
    assign rotl  = (num << amt) | (num >> (WIDTH - int'(amt)));
    assign rotr  = (num >> amt) | (num << (WIDTH - int'(amt)));
    assign sra   = s_num >>> amt;

    always_comb begin
        shifted = num << amt;
        if (dir == DIR_LEFT) begin
            if (mode == MODE_ROTATE) shifted = rotl;
            else                     shifted = num << amt;
        end else begin
            case (mode)
                MODE_ARITH:  shifted = sra;
                MODE_ROTATE: shifted = rotr;
                default:     shifted = num >> amt;
            endcase
        end
    end

endmodule

// File: rtl/shift_console.sv
// Shift console: a register loaded from switches, shifted/rotated by
// command pulses, with a circular undo history and a multiplexed hex display.
// Ports: mclk/reset (async active-high), sw (load value), amt, mode,
// load/left/right/undo ticks, result, depth (valid undo entries),
// err (one-cycle pulse on rejected command), digit/an (display scan, an active-low).
module shift_console
    import shift_console_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int REFRESH_BITS = 20,
    localparam int DIGITS      = WIDTH / 4,
    localparam int AW          = $clog2(WIDTH),
    localparam int DW          = $clog2(DEPTH + 1)
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  sw,
    input  logic [AW-1:0]     amt,
    input  logic [1:0]        mode,
    input  logic              load_tick,
    input  logic              left_tick,
    input  logic              right_tick,
    input  logic              undo_tick,
    output logic [WIDTH-1:0]  result,
    output logic [DW-1:0]     depth,
    output logic              err,
    output logic [3:0]        digit,
    output logic [DIGITS-1:0] an
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = $clog2(DIGITS);

    if (!params_legal(WIDTH, DEPTH)) begin : g_bad_params
        $error("shift_console: illegal WIDTH/DEPTH");
    end

    logic [WIDTH-1:0]        hist [DEPTH];
    logic [PW-1:0]           head;
    logic [PW-1:0]           head_next;
    logic [PW-1:0]           head_prev;
    logic [REFRESH_BITS-1:0] scan;
    logic [IW-1:0]           idx;
    logic [WIDTH-1:0]        shifted;
    logic [WIDTH-1:0]        digit_sh;
    logic [2:0]              n_ticks;
    logic                    multi;
    logic                    push;

    assign n_ticks = {2'b00, load_tick} + {2'b00, left_tick} +
                     {2'b00, right_tick} + {2'b00, undo_tick};
    assign multi   = (n_ticks > 3'd1);
    assign push    = !multi && (load_tick || left_tick || right_tick);

    // head points at the next slot to write; when full that slot is the oldest.
    assign head_next = (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
    assign head_prev = (head == '0) ? PW'(DEPTH - 1) : head - 1'b1;

    shift_core #(.WIDTH(WIDTH), .AW(AW)) u_core (
        .num     (result),
        .amt     (amt),
        .mode    (mode),
        .dir     (right_tick ? DIR_RIGHT : DIR_LEFT),
        .shifted (shifted)
    );

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            result <= '0;
            depth  <= '0;
            head   <= '0;
            err    <= 1'b0;
            scan   <= '0;
        end else begin
            scan <= scan + 1'b1;
            err  <= 1'b0;
            if (multi) begin
                err <= 1'b1;
            end else if (push) begin
                result <= load_tick ? sw : shifted;
                head   <= head_next;
                if (depth != DW'(DEPTH)) depth <= depth + 1'b1;
            end else if (undo_tick) begin
                if (depth == '0) begin
                    err <= 1'b1;
                end else begin
                    result <= hist[head_prev];
                    head   <= head_prev;
                    depth  <= depth - 1'b1;
                end
            end
        end
    end

    // History contents are never cleared; depth alone marks which are valid.
    always_ff @(posedge mclk) begin
        if (!reset && push) hist[head] <= result;
    end

    assign idx      = scan[REFRESH_BITS-1 -: IW];
    assign digit_sh = result >> {idx, 2'b00};
    assign digit    = digit_sh[3:0];
    assign an       = ~(DIGITS'(1) << idx);

endmodule

// File: tb/tb_shift_console.sv
module tb_shift_console;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int RB    = 4;

    logic       mclk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw = '0;
    logic [2:0] amt = '0;
    logic [1:0] mode = '0;
    logic       load_tick = 1'b0, left_tick = 1'b0, right_tick = 1'b0, undo_tick = 1'b0;
    logic [7:0] result;
    logic [2:0] depth;
    logic       err;
    logic [3:0] digit;
    logic [1:0] an;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int m_res = 0;
    int m_err = 0;
    int m_hist[$];
    int scan_m = 0;

    shift_console #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REFRESH_BITS(RB)) dut (
        .mclk(mclk), .reset(reset), .sw(sw), .amt(amt), .mode(mode),
        .load_tick(load_tick), .left_tick(left_tick), .right_tick(right_tick),
        .undo_tick(undo_tick), .result(result), .depth(depth), .err(err),
        .digit(digit), .an(an)
    );

    always #5 mclk = ~mclk;

    // free-running cycle count since reset release
    always @(posedge mclk or posedge reset) begin
        if (reset) scan_m <= 0;
        else       scan_m <= (scan_m + 1) % (1 << RB);
    end

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_left(input int r, input int a, input int m);
        if (m == 2) return ((r << a) | (r >> (8 - a))) & 8'hFF;
        return (r << a) & 8'hFF;
    endfunction

    function automatic int ref_right(input int r, input int a, input int m);
        if (m == 1) return (r[7] ? ((r >> a) | (8'hFF << (8 - a))) : (r >> a)) & 8'hFF;
        if (m == 2) return ((r >> a) | (r << (8 - a))) & 8'hFF;
        return r >> a;
    endfunction

    task automatic check_outputs();
        int k;
        k = scan_m / (1 << (RB - 1));
        chk("result", int'(result), m_res);
        chk("depth", int'(depth), m_hist.size());
        chk("err", int'(err), m_err);
        chk("an", int'(an), (~(1 << k)) & 3);
        chk("digit", int'(digit), (m_res >> (4 * k)) & 4'hF);
    endtask

    task automatic step(input logic l, input logic lf, input logic rt, input logic u,
                        input logic [7:0] s, input logic [2:0] a, input logic [1:0] m);
        int n;
        sw = s; amt = a; mode = m;
        load_tick = l; left_tick = lf; right_tick = rt; undo_tick = u;
        @(posedge mclk);
        #1;
        load_tick = 0; left_tick = 0; right_tick = 0; undo_tick = 0;
        n = int'(l) + int'(lf) + int'(rt) + int'(u);
        m_err = 0;
        if (n > 1) begin
            m_err = 1;
        end else if (l || lf || rt) begin
            if (m_hist.size() == DEPTH) void'(m_hist.pop_front());
            m_hist.push_back(m_res);
            if (l)       m_res = int'(s);
            else if (lf) m_res = ref_left(m_res, int'(a), int'(m));
            else         m_res = ref_right(m_res, int'(a), int'(m));
        end else if (u) begin
            if (m_hist.size() == 0) m_err = 1;
            else                    m_res = m_hist.pop_back();
        end
        check_outputs();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, sw, amt, mode);
    endtask

    // Reset asserted while a right tick is present; the tick must be lost.
    task automatic apply_reset();
        right_tick = 1;
        reset = 1;
        #1;
        chk("rst_result_async", int'(result), 0);
        chk("rst_depth_async", int'(depth), 0);
        @(posedge mclk);
        #1;
        reset = 0;
        right_tick = 0;
        m_res = 0; m_err = 0; m_hist.delete();
        check_outputs();
    endtask

    initial begin
        int lo_cnt, hi_cnt, pick, i, j;
        logic [3:0] t;
        #2;
        chk("reset_result", int'(result), 0);
        chk("reset_depth", int'(depth), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_an", int'(an), 2'b10);
        chk("reset_digit", int'(digit), 0);
        @(posedge mclk);
        #1;
        reset = 0;
        check_outputs();

        // load then the three shift kinds from 0xB4
        step(1, 0, 0, 0, 8'hB4, 3'd0, 2'd0);
        chk("load_b4", int'(result), 8'hB4);
        chk("load_depth", int'(depth), 1);
        step(0, 0, 1, 0, 8'h00, 3'd2, 2'd0);
        chk("lsr_2", int'(result), 8'h2D);
        step(1, 0, 0, 0, 8'hB4, 3'd0, 2'd0);
        step(0, 0, 1, 0, 8'h00, 3'd2, 2'd1);
        chk("asr_2", int'(result), 8'hED);
        step(1, 0, 0, 0, 8'hB4, 3'd0, 2'd0);
        step(0, 1, 0, 0, 8'h00, 3'd3, 2'd2);
        chk("rol_3", int'(result), 8'hA5);
        step(0, 1, 0, 0, 8'h00, 3'd0, 2'd2);
        chk("amt0_keeps", int'(result), 8'hA5);

        // history overflow and undo to empty
        step(1, 0, 0, 0, 8'h01, 3'd0, 2'd0);
        for (int n = 0; n < 5; n++) step(0, 1, 0, 0, 8'h00, 3'd1, 2'd0);
        chk("shl_five", int'(result), 8'h20);
        chk("full_depth", int'(depth), 4);
        for (int n = 0; n < 4; n++) step(0, 0, 0, 1, 8'h00, 3'd0, 2'd0);
        chk("undo_to_02", int'(result), 8'h02);
        step(0, 0, 0, 1, 8'h00, 3'd0, 2'd0);
        chk("undo_empty_err", int'(err), 1);
        chk("undo_empty_res", int'(result), 8'h02);
        idle();
        chk("err_one_cycle", int'(err), 0);

        // simultaneous ticks
        step(1, 0, 0, 0, 8'h5A, 3'd0, 2'd0);
        step(1, 1, 0, 0, 8'hFF, 3'd1, 2'd0);
        chk("multi_keep", int'(result), 8'h5A);
        chk("multi_err", int'(err), 1);
        idle();
        chk("multi_err_clear", int'(err), 0);

        // reset between two right ticks
        step(0, 0, 1, 0, 8'h00, 3'd1, 2'd0);
        apply_reset();
        step(0, 0, 0, 1, 8'h00, 3'd0, 2'd0);
        chk("undo_after_reset", int'(err), 1);

        // display scan over one full counter period
        step(1, 0, 0, 0, 8'h3C, 3'd0, 2'd0);
        lo_cnt = 0; hi_cnt = 0;
        for (int n = 0; n < (1 << RB); n++) begin
            idle();
            if (an == 2'b10 && digit == 4'hC) lo_cnt++;
            if (an == 2'b01 && digit == 4'h3) hi_cnt++;
        end
        chk("scan_digit0_cycles", lo_cnt, 1 << (RB - 1));
        chk("scan_digit1_cycles", hi_cnt, 1 << (RB - 1));

        // randomized commands
        for (int n = 0; n < 400; n++) begin
            pick = $urandom_range(0, 39);
            t = 4'b0000;
            if (pick == 39) begin
                apply_reset();
            end else begin
                case (pick % 10)
                    0, 1, 2: t = 4'b1000;
                    3, 4:    t = 4'b0100;
                    5, 6:    t = 4'b0010;
                    7:       t = 4'b0001;
                    8:       t = 4'b0000;
                    default: begin
                        i = $urandom_range(0, 3);
                        j = (i + $urandom_range(1, 3)) % 4;
                        t[i] = 1'b1;
                        t[j] = 1'b1;
                    end
                endcase
                step(t[3], t[2], t[1], t[0], 8'($urandom), 3'($urandom), 2'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
